// File: rtl/id_ex_pipeline_reg.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_pipeline_reg
//  Description : Decode->Execute pipeline register. Captures decoder control,
//                ALU control, operands and register addresses; supports
//                stall (hold), flush (bubble) and upstream-invalid squash.
//                Keeps a saturating count of bubbles entering Execute.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_pipeline_reg #(
  parameter int XLEN  = 32,
  parameter int RAW   = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic             ValidD,
  // decoder control
  input  logic             RegWriteD,
  input  logic [1:0]       ResultSrcD,
  input  logic             MemWriteD,
  input  logic             JumpD,
  input  logic             BranchD,
  input  logic             ALUSrcD,
  input  logic [2:0]       ALUControlD,
  // data
  input  logic [XLEN-1:0]  RD1D,
  input  logic [XLEN-1:0]  RD2D,
  input  logic [XLEN-1:0]  PCD,
  input  logic [XLEN-1:0]  PCPlus4D,
  input  logic [XLEN-1:0]  ImmExtD,
  // register addresses
  input  logic [RAW-1:0]   Rs1D,
  input  logic [RAW-1:0]   Rs2D,
  input  logic [RAW-1:0]   RdD,
  // registered copies
  output logic             RegWriteE,
  output logic [1:0]       ResultSrcE,
  output logic             MemWriteE,
  output logic             JumpE,
  output logic             BranchE,
  output logic             ALUSrcE,
  output logic [2:0]       ALUControlE,
  output logic [XLEN-1:0]  RD1E,
  output logic [XLEN-1:0]  RD2E,
  output logic [XLEN-1:0]  PCE,
  output logic [XLEN-1:0]  PCPlus4E,
  output logic [XLEN-1:0]  ImmExtE,
  output logic [RAW-1:0]   Rs1E,
  output logic [RAW-1:0]   Rs2E,
  output logic [RAW-1:0]   RdE,
  output logic             ValidE,
  output logic [CNT_W-1:0] BubbleCount
);

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  // control-field state
  logic             reg_write_q,   reg_write_d;
  logic [1:0]       result_src_q,  result_src_d;
  logic             mem_write_q,   mem_write_d;
  logic             jump_q,        jump_d;
  logic             branch_q,      branch_d;
  logic             alu_src_q,     alu_src_d;
  logic [2:0]       alu_control_q, alu_control_d;

  // data / address state
  logic [XLEN-1:0]  rd1_q,      rd1_d;
  logic [XLEN-1:0]  rd2_q,      rd2_d;
  logic [XLEN-1:0]  pc_q,       pc_d;
  logic [XLEN-1:0]  pc_plus4_q, pc_plus4_d;
  logic [XLEN-1:0]  imm_ext_q,  imm_ext_d;
  logic [RAW-1:0]   rs1_q,      rs1_d;
  logic [RAW-1:0]   rs2_q,      rs2_d;
  logic [RAW-1:0]   rd_q,       rd_d;

  // status state
  logic             valid_q,    valid_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Edge classification: a flush always wins, otherwise a stall freezes the stage.
  logic w_load;
  logic w_bubble;

  // Decide what this edge does to the stage and whether it injects a bubble.
  always_comb begin
    w_load   = 1'b0;
    w_bubble = 1'b0;
    if (FlushE) begin
      w_bubble = 1'b1;
    end else if (!StallE) begin
      w_load   = 1'b1;
      w_bubble = !ValidD;
    end
  end

  // Control fields: zero on flush or on an invalid upstream slot, so E sees a NOP.
  always_comb begin
    reg_write_d   = reg_write_q;
    result_src_d  = result_src_q;
    mem_write_d   = mem_write_q;
    jump_d        = jump_q;
    branch_d      = branch_q;
    alu_src_d     = alu_src_q;
    alu_control_d = alu_control_q;
    if (FlushE || (w_load && !ValidD)) begin
      reg_write_d   = 1'b0;
      result_src_d  = 2'b00;
      mem_write_d   = 1'b0;
      jump_d        = 1'b0;
      branch_d      = 1'b0;
      alu_src_d     = 1'b0;
      alu_control_d = 3'b000;
    end else if (w_load) begin
      reg_write_d   = RegWriteD;
      result_src_d  = ResultSrcD;
      mem_write_d   = MemWriteD;
      jump_d        = JumpD;
      branch_d      = BranchD;
      alu_src_d     = ALUSrcD;
      alu_control_d = ALUControlD;
    end
  end

  // Data and address fields: cleared by flush, loaded regardless of ValidD.
  always_comb begin
    rd1_d      = rd1_q;
    rd2_d      = rd2_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    imm_ext_d  = imm_ext_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    if (FlushE) begin
      rd1_d      = '0;
      rd2_d      = '0;
      pc_d       = '0;
      pc_plus4_d = '0;
      imm_ext_d  = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      rd_d       = '0;
    end else if (w_load) begin
      rd1_d      = RD1D;
      rd2_d      = RD2D;
      pc_d       = PCD;
      pc_plus4_d = PCPlus4D;
      imm_ext_d  = ImmExtD;
      rs1_d      = Rs1D;
      rs2_d      = Rs2D;
      rd_d       = RdD;
    end
  end

  // Valid flag and saturating bubble counter; stalled edges leave both untouched.
  always_comb begin
    valid_d      = valid_q;
    bubble_cnt_d = bubble_cnt_q;
    if (FlushE) begin
      valid_d = 1'b0;
    end else if (w_load) begin
      valid_d = ValidD;
    end
    if (w_bubble && (bubble_cnt_q != C_CNT_MAX)) begin
      bubble_cnt_d = bubble_cnt_q + C_CNT_ONE;
    end
  end

  // Control register bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_q   <= 1'b0;
      result_src_q  <= 2'b00;
      mem_write_q   <= 1'b0;
      jump_q        <= 1'b0;
      branch_q      <= 1'b0;
      alu_src_q     <= 1'b0;
      alu_control_q <= 3'b000;
    end else begin
      reg_write_q   <= reg_write_d;
      result_src_q  <= result_src_d;
      mem_write_q   <= mem_write_d;
      jump_q        <= jump_d;
      branch_q      <= branch_d;
      alu_src_q     <= alu_src_d;
      alu_control_q <= alu_control_d;
    end
  end

  // Data and address register bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd1_q      <= '0;
      rd2_q      <= '0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      imm_ext_q  <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
    end else begin
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      imm_ext_q  <= imm_ext_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
    end
  end

  // Status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // Outputs come straight from flops: no input-to-output combinational path.
  assign RegWriteE   = reg_write_q;
  assign ResultSrcE  = result_src_q;
  assign MemWriteE   = mem_write_q;
  assign JumpE       = jump_q;
  assign BranchE     = branch_q;
  assign ALUSrcE     = alu_src_q;
  assign ALUControlE = alu_control_q;
  assign RD1E        = rd1_q;
  assign RD2E        = rd2_q;
  assign PCE         = pc_q;
  assign PCPlus4E    = pc_plus4_q;
  assign ImmExtE     = imm_ext_q;
  assign Rs1E        = rs1_q;
  assign Rs2E        = rs2_q;
  assign RdE         = rd_q;
  assign ValidE      = valid_q;
  assign BubbleCount = bubble_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipeline_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_pipeline_reg
//  Description : Directed self-checking bench for id_ex_pipeline_reg, with a
//                default instance and a CNT_W=4 instance for saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_pipeline_reg;

  localparam int XLEN = 32;
  localparam int RAW  = 5;

  logic clk = 1'b0;
  logic reset, StallE, FlushE, ValidD;
  logic RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0] ResultSrcD;
  logic [2:0] ALUControlD;
  logic [XLEN-1:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
  logic [RAW-1:0] Rs1D, Rs2D, RdD;

  logic RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE;
  logic [1:0] ResultSrcE;
  logic [2:0] ALUControlE;
  logic [XLEN-1:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
  logic [RAW-1:0] Rs1E, Rs2E, RdE;
  logic [15:0] BubbleCount;

  logic s_RegWriteE, s_MemWriteE, s_JumpE, s_BranchE, s_ALUSrcE, s_ValidE;
  logic [1:0] s_ResultSrcE;
  logic [2:0] s_ALUControlE;
  logic [XLEN-1:0] s_RD1E, s_RD2E, s_PCE, s_PCPlus4E, s_ImmExtE;
  logic [RAW-1:0] s_Rs1E, s_Rs2E, s_RdE;
  logic [3:0] s_BubbleCount;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_pipeline_reg #(.XLEN(XLEN), .RAW(RAW), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
    .JumpD(JumpD), .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ValidE(ValidE), .BubbleCount(BubbleCount)
  );

  id_ex_pipeline_reg #(.XLEN(XLEN), .RAW(RAW), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
    .JumpD(JumpD), .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteE(s_RegWriteE), .ResultSrcE(s_ResultSrcE), .MemWriteE(s_MemWriteE),
    .JumpE(s_JumpE), .BranchE(s_BranchE), .ALUSrcE(s_ALUSrcE), .ALUControlE(s_ALUControlE),
    .RD1E(s_RD1E), .RD2E(s_RD2E), .PCE(s_PCE), .PCPlus4E(s_PCPlus4E), .ImmExtE(s_ImmExtE),
    .Rs1E(s_Rs1E), .Rs2E(s_Rs2E), .RdE(s_RdE), .ValidE(s_ValidE), .BubbleCount(s_BubbleCount)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_d();
    StallE = 0; FlushE = 0; ValidD = 0;
    RegWriteD = 0; ResultSrcD = 2'b00; MemWriteD = 0; JumpD = 0; BranchD = 0;
    ALUSrcD = 0; ALUControlD = 3'b000;
    RD1D = '0; RD2D = '0; PCD = '0; PCPlus4D = '0; ImmExtD = '0;
    Rs1D = '0; Rs2D = '0; RdD = '0;
  endtask

  initial begin
    int exp16;
    int exp4;
    reset = 1'b1;
    clear_d();
    step();
    step();
    chk("rst_valid", ValidE, 0);
    chk("rst_cnt", BubbleCount, 0);
    reset = 1'b0;

    // Reset mid-run: make a bubble and a real load, then reset between edges.
    FlushE = 1;
    step();
    chk("pre_flush_cnt", BubbleCount, 1);
    clear_d();
    RegWriteD = 1; RD1D = 32'h1234; ValidD = 1;
    step();
    chk("pre_rst_regwrite", RegWriteE, 1);
    chk("pre_rst_rd1", RD1E, 32'h1234);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_regwrite", RegWriteE, 0);
    chk("async_rst_rd1", RD1E, 0);
    chk("async_rst_valid", ValidE, 0);
    chk("async_rst_cnt", BubbleCount, 0);
    #1 reset = 1'b0;

    // Load a lw.
    clear_d();
    RegWriteD = 1; ResultSrcD = 2'b01; ALUSrcD = 1; ImmExtD = 32'h8; RdD = 5'd7; ValidD = 1;
    step();
    chk("lw_regwrite", RegWriteE, 1);
    chk("lw_resultsrc", ResultSrcE, 2'b01);
    chk("lw_alusrc", ALUSrcE, 1);
    chk("lw_imm", ImmExtE, 32'h8);
    chk("lw_rd", RdE, 5'd7);
    chk("lw_memwrite", MemWriteE, 0);
    chk("lw_valid", ValidE, 1);
    chk("lw_cnt", BubbleCount, 0);

    // Stall for 3 cycles with changing D inputs.
    for (int i = 0; i < 3; i++) begin
      StallE = 1; ValidD = 0; RegWriteD = 0; ImmExtD = 32'hFFFF_0000 + i; RdD = 5'(i + 1);
      step();
      chk("stall_imm", ImmExtE, 32'h8);
      chk("stall_rd", RdE, 5'd7);
      chk("stall_regwrite", RegWriteE, 1);
      chk("stall_valid", ValidE, 1);
      chk("stall_cnt", BubbleCount, 0);
    end

    // Load a sw, then flush with a simultaneous stall.
    clear_d();
    MemWriteD = 1; ALUSrcD = 1; RD2D = 32'h55; ImmExtD = 32'h10; ValidD = 1;
    step();
    chk("sw_memwrite", MemWriteE, 1);
    chk("sw_rd2", RD2E, 32'h55);
    FlushE = 1; StallE = 1;
    step();
    chk("flush_memwrite", MemWriteE, 0);
    chk("flush_alusrc", ALUSrcE, 0);
    chk("flush_rd2", RD2E, 0);
    chk("flush_imm", ImmExtE, 0);
    chk("flush_valid", ValidE, 0);
    chk("flush_cnt", BubbleCount, 1);

    // Stalled edge with ValidE already 0 must not count.
    FlushE = 0; StallE = 1; ValidD = 0;
    step();
    chk("stall_bubble_cnt", BubbleCount, 1);

    // Upstream invalid squash.
    clear_d();
    ValidD = 0; RegWriteD = 1; JumpD = 1; RD2D = 32'hABCD; ALUControlD = 3'b010; PCD = 32'h100;
    step();
    chk("inv_regwrite", RegWriteE, 0);
    chk("inv_jump", JumpE, 0);
    chk("inv_aluctl", ALUControlE, 0);
    chk("inv_rd2", RD2E, 32'hABCD);
    chk("inv_pc", PCE, 32'h100);
    chk("inv_valid", ValidE, 0);
    chk("inv_cnt", BubbleCount, 2);

    // Branch with PC+4 result source and wide addresses.
    clear_d();
    ValidD = 1; ResultSrcD = 2'b10; BranchD = 1; ALUControlD = 3'b101;
    Rs1D = 5'd9; Rs2D = 5'd31; PCPlus4D = 32'h104; RD1D = 32'hDEAD_BEEF;
    step();
    chk("br_resultsrc", ResultSrcE, 2'b10);
    chk("br_branch", BranchE, 1);
    chk("br_aluctl", ALUControlE, 3'b101);
    chk("br_rs1", Rs1E, 5'd9);
    chk("br_rs2", Rs2E, 5'd31);
    chk("br_pcplus4", PCPlus4E, 32'h104);
    chk("br_rd1", RD1E, 32'hDEAD_BEEF);
    chk("br_valid", ValidE, 1);
    chk("br_cnt", BubbleCount, 2);
    chk("sat_pre_cnt", s_BubbleCount, 2);

    // Saturation: 20 consecutive flushes; the 4-bit counter stops at F.
    exp16 = 2;
    exp4  = 2;
    FlushE = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      exp16 = exp16 + 1;
      exp4  = (exp4 < 15) ? exp4 + 1 : 15;
      chk("sat4_cnt", s_BubbleCount, 64'(exp4));
      chk("sat16_cnt", BubbleCount, 64'(exp16));
    end
    chk("sat4_final", s_BubbleCount, 4'hF);
    chk("sat16_final", BubbleCount, 16'd22);

    // Load with ValidD=0 at saturation still holds F.
    FlushE = 0; ValidD = 0;
    step();
    chk("sat4_hold", s_BubbleCount, 4'hF);
    chk("sat16_after", BubbleCount, 16'd23);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
`default_nettype wire
